micro_sequencer: RTL and testbench

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

---
 rtl/micro_sequencer.sv | 95 +++++++++
 tb/tb_micro_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// Micro-PC sequencer with retired-instruction counter.
// Optional illegal-opcode trap enabled by defining ILLEGAL_OP_TRAP_EN.
module micro_sequencer #(
    parameter int UPC_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       addr_ctl,
    input  logic             stall,
    input  logic [UPC_W-1:0] disp1,
    input  logic [UPC_W-1:0] disp2,
    output logic [UPC_W-1:0] upc,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             trap
);

    typedef enum logic [1:0] {
        AC_FETCH = 2'b00,
        AC_DISP1 = 2'b01,
        AC_DISP2 = 2'b10,
        AC_INC   = 2'b11
    } addr_ctl_e;

    addr_ctl_e        ac;
    logic [UPC_W-1:0] upc_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    assign ac = addr_ctl_e'(addr_ctl);

`ifdef ILLEGAL_OP_TRAP_EN
    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_TRAPPED = 1'b1
    } state_e;

    state_e state, state_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    assign trap = (state == ST_TRAPPED);
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        upc_nxt = upc;
        cnt_nxt = instr_cnt;
`ifdef ILLEGAL_OP_TRAP_EN
        state_nxt = state;
`endif
        if (!stall) begin
            unique case (ac)
                AC_FETCH: begin
                    upc_nxt = '0;
                    // A fetch from upc 0 is the idle loop, not a retirement
                    if (upc != '0) begin
                        cnt_nxt = instr_cnt + CNT_W'(1);
                    end
                end
                AC_DISP1: upc_nxt = disp1;
                AC_DISP2: upc_nxt = disp2;
                AC_INC:   upc_nxt = upc + UPC_W'(1);
            endcase
`ifdef ILLEGAL_OP_TRAP_EN
            // Trap handling overrides the normal sequencing decision above
            if (state == ST_TRAPPED) begin
                upc_nxt = '1;
                cnt_nxt = instr_cnt;
            end else if (ac == AC_DISP1 && disp1 == '0) begin
                upc_nxt   = '1;
                cnt_nxt   = instr_cnt;
                state_nxt = ST_TRAPPED;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            upc       <= '0;
            instr_cnt <= '0;
        end else begin
            upc       <= upc_nxt;
            instr_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer with a behavioural model checked every cycle.
// Counter width is reduced so the counter wrap is reachable quickly.
module tb_micro_sequencer;

    localparam int UPC_W = 4;
    localparam int CNT_W = 4;
    localparam int UPC_M = (1 << UPC_W) - 1;
    localparam int CNT_M = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset_n;
    logic [1:0]       addr_ctl;
    logic             stall;
    logic [UPC_W-1:0] disp1;
    logic [UPC_W-1:0] disp2;
    logic [UPC_W-1:0] upc;
    logic [CNT_W-1:0] instr_cnt;
    logic             trap;

    int tests;
    int fails;

    // Model state
    int m_upc;
    int m_cnt;
    bit m_trap;

    micro_sequencer #(
        .UPC_W(UPC_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .addr_ctl (addr_ctl),
        .stall    (stall),
        .disp1    (disp1),
        .disp2    (disp2),
        .upc      (upc),
        .instr_cnt(instr_cnt),
        .trap     (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_upc  = 0;
        m_cnt  = 0;
        m_trap = 0;
    endtask

    task automatic model_step(input int ctl, input int d1, input int d2, input bit st);
        if (st) return;
        if (m_trap) begin
            m_upc = UPC_M;
            return;
        end
        case (ctl)
            0: begin
                if (m_upc != 0) m_cnt = (m_cnt + 1) & CNT_M;
                m_upc = 0;
            end
            1: begin
`ifdef ILLEGAL_OP_TRAP_EN
                if (d1 == 0) begin
                    m_trap = 1;
                    m_upc  = UPC_M;
                end else begin
                    m_upc = d1;
                end
`else
                m_upc = d1;
`endif
            end
            2: m_upc = d2;
            default: m_upc = (m_upc + 1) & UPC_M;
        endcase
    endtask

    task automatic cyc(input int ctl, input int d1, input int d2, input bit st);
        addr_ctl = 2'(ctl);
        disp1    = UPC_W'(d1);
        disp2    = UPC_W'(d2);
        stall    = st;
        @(posedge clk);
        model_step(ctl, d1, d2, st);
        #1;
    endtask

    // Asserted between clock edges; checked before any edge can occur
    task automatic async_reset(input string nm);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk({nm, "_upc"}, int'(upc), 0);
        chk({nm, "_cnt"}, int'(instr_cnt), 0);
        chk({nm, "_trap"}, int'(trap), 0);
        #1;
        reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        tests++;
        if (int'(upc) != m_upc || int'(instr_cnt) != m_cnt || int'(trap) != int'(m_trap)) begin
            fails++;
            $display("FAIL model_cmp: upc=%0d cnt=%0d trap=%0d expected upc=%0d cnt=%0d trap=%0d (t=%0t)",
                     upc, instr_cnt, trap, m_upc, m_cnt, m_trap, $time);
        end
    end

    initial begin
        tests    = 0;
        fails    = 0;
        reset_n  = 1'b0;
        addr_ctl = 2'b00;
        stall    = 1'b0;
        disp1    = '0;
        disp2    = '0;
        model_reset();
        #2;
        chk("por_upc", int'(upc), 0);
        chk("por_cnt", int'(instr_cnt), 0);
        chk("por_trap", int'(trap), 0);
        #10 reset_n = 1'b1;

        // R-type: 0 -> 1 -> 6 -> 7 -> 0
        cyc(3, 0, 0, 0); chk("r_upc1", int'(upc), 1);
        cyc(1, 6, 9, 0); chk("r_upc6", int'(upc), 6);
        cyc(3, 0, 0, 0); chk("r_upc7", int'(upc), 7);
        chk("r_cnt_before", int'(instr_cnt), 0);
        cyc(0, 0, 0, 0); chk("r_upc0", int'(upc), 0);
        chk("r_cnt_after", int'(instr_cnt), 1);

        // Load: 0 -> 1 -> 2 -> 3 -> 4 -> 0
        cyc(3, 0, 0, 0); chk("ld_upc1", int'(upc), 1);
        cyc(1, 2, 7, 0); chk("ld_upc2", int'(upc), 2);
        cyc(2, 9, 3, 0); chk("ld_upc3", int'(upc), 3);
        cyc(3, 0, 0, 0); chk("ld_upc4", int'(upc), 4);
        cyc(0, 0, 0, 0); chk("ld_upc0", int'(upc), 0);
        chk("ld_cnt", int'(instr_cnt), 2);

        // Stall at upc 6 for three edges, fetch requested to prove priority
        cyc(1, 6, 0, 0); chk("st_upc6", int'(upc), 6);
        for (int i = 0; i < 3; i++) begin
            cyc(3, 0, 0, 1);
            chk("st_hold_upc", int'(upc), 6);
            chk("st_hold_cnt", int'(instr_cnt), 2);
        end
        cyc(0, 0, 0, 1); chk("st_fetch_cnt", int'(instr_cnt), 2);
        cyc(3, 0, 0, 0); chk("st_release", int'(upc), 7);
        cyc(0, 0, 0, 0); chk("st_retire", int'(instr_cnt), 3);

        // upc wrap 15 -> 0 without trap, then idle fetch must not count
        cyc(1, 15, 0, 0); chk("wr_upc15", int'(upc), 15);
        cyc(3, 0, 0, 0); chk("wr_upc0", int'(upc), 0);
        chk("wr_trap", int'(trap), 0);
        cyc(0, 0, 0, 0); chk("idle_fetch_cnt", int'(instr_cnt), 3);

        // Counter wrap: bring counter to all-ones then retire once more
        for (int i = 0; i < 12; i++) begin
            cyc(3, 0, 0, 0);
            cyc(0, 0, 0, 0);
        end
        chk("cnt_full", int'(instr_cnt), 15);
        cyc(3, 0, 0, 0);
        cyc(0, 0, 0, 0); chk("cnt_wrap", int'(instr_cnt), 0);

        // Mid-run reset at upc 5, then restart from fetch
        cyc(3, 0, 0, 0);
        cyc(1, 5, 0, 0); chk("mr_upc5", int'(upc), 5);
        async_reset("mr");
        cyc(3, 0, 0, 0); chk("mr_restart", int'(upc), 1);

        // Reset while stalled
        cyc(3, 0, 0, 1);
        async_reset("msr");
        cyc(3, 0, 0, 0); chk("msr_restart", int'(upc), 1);
        cyc(0, 0, 0, 0); chk("msr_cnt", int'(instr_cnt), 1);

        // Unmapped opcode
        cyc(3, 0, 0, 0);
        cyc(1, 0, 4, 0);
`ifdef ILLEGAL_OP_TRAP_EN
        chk("ill_trap", int'(trap), 1);
        chk("ill_upc", int'(upc), 15);
        for (int i = 0; i < 4; i++) begin
            cyc(i, 5, 6, 0);
            chk("trp_upc", int'(upc), 15);
            chk("trp_trap", int'(trap), 1);
            chk("trp_cnt", int'(instr_cnt), 1);
        end
        async_reset("trp_rst");
        cyc(3, 0, 0, 0); chk("trp_restart", int'(upc), 1);
`else
        chk("ill_upc", int'(upc), 0);
        chk("ill_trap", int'(trap), 0);
        chk("ill_cnt", int'(instr_cnt), 1);
        cyc(3, 0, 0, 0); chk("ill_continue", int'(upc), 1);
`endif

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
